// File: rtl/axi_lite_regbank_if.sv
// AXI4-Lite bus bundle between one bus master port and an axi_lite_regbank.
// The master modport drives requests; the slave modport drives ready/response.
interface axi_lite_regbank_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8:0]   wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [RESP_WIDTH-1:0]   bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [RESP_WIDTH-1:0]   rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave bank of NUM_REGS 32-bit registers in a BASE_ADDR window.
// Optional macro REGBANK_SLVERR_EN: out-of-window accesses answer SLVERR instead of OKAY.
module axi_lite_regbank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3,
    parameter int NUM_REGS   = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic                s_axi_aclk,
    input  logic                s_axi_aresetn,
    axi_lite_regbank_if.slave   s_axi
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   SPAN = (ADDR_WIDTH+1)'(NUM_REGS * 4);
    localparam logic [RESP_WIDTH-1:0] RESP_OKAY = '0;
`ifdef REGBANK_SLVERR_EN
    localparam logic [RESP_WIDTH-1:0] MISS_RESP = RESP_WIDTH'(2);
`else
    localparam logic [RESP_WIDTH-1:0] MISS_RESP = RESP_OKAY;
`endif

    typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // Offsets below BASE wrap to large values and therefore miss.
    function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] offset;
        offset = addr - BASE;
        return ({1'b0, offset} < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] offset;
        offset = addr - BASE;
        return offset[IDX_W+1:2];
    endfunction

    w_state_t                w_state, w_state_nx;
    r_state_t                r_state, r_state_nx;
    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
    logic [ADDR_WIDTH-1:0]   aw_addr_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
    logic [NBYTES-1:0]       w_strb_q;
    logic [RESP_WIDTH-1:0]   bresp_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [RESP_WIDTH-1:0]   rresp_q;
    logic                    aw_hs, w_hs, ar_hs;
    logic                    commit;
    logic [ADDR_WIDTH-1:0]   cm_addr;
    logic [DATA_WIDTH-1:0]   cm_data;
    logic [NBYTES-1:0]       cm_strb;
    logic                    cm_hit;
    logic [IDX_W-1:0]        cm_idx;
    logic                    rd_hit;
    logic [IDX_W-1:0]        rd_idx;
    logic                    unused_strb_msb;

    assign unused_strb_msb = s_axi.wstrb[NBYTES];

    assign s_axi.awready = (w_state == W_IDLE) || (w_state == W_HAVE_DATA);
    assign s_axi.wready  = (w_state == W_IDLE) || (w_state == W_HAVE_ADDR);
    assign s_axi.bvalid  = (w_state == W_RESP);
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = (r_state == R_IDLE);
    assign s_axi.rvalid  = (r_state == R_DATA);
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

    assign aw_hs = s_axi.awvalid && s_axi.awready;
    assign w_hs  = s_axi.wvalid  && s_axi.wready;
    assign ar_hs = s_axi.arvalid && s_axi.arready;

    // Commit picks live bus fields or the half that arrived earlier.
    always_comb begin
        w_state_nx = w_state;
        commit     = 1'b0;
        cm_addr    = s_axi.awaddr;
        cm_data    = s_axi.wdata;
        cm_strb    = s_axi.wstrb[NBYTES-1:0];
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit     = 1'b1;
                    w_state_nx = W_RESP;
                end else if (aw_hs) begin
                    w_state_nx = W_HAVE_ADDR;
                end else if (w_hs) begin
                    w_state_nx = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                if (w_hs) begin
                    commit     = 1'b1;
                    cm_addr    = aw_addr_q;
                    w_state_nx = W_RESP;
                end
            end
            W_HAVE_DATA: begin
                if (aw_hs) begin
                    commit     = 1'b1;
                    cm_data    = w_data_q;
                    cm_strb    = w_strb_q;
                    w_state_nx = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi.bready) w_state_nx = W_IDLE;
            end
            default: w_state_nx = W_IDLE;
        endcase
    end

    assign cm_hit = addr_hit(cm_addr);
    assign cm_idx = addr_idx(cm_addr);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            w_state <= W_IDLE;
            bresp_q <= '0;
        end else begin
            w_state <= w_state_nx;
            if (commit) bresp_q <= cm_hit ? RESP_OKAY : MISS_RESP;
        end
    end

    // Half-transaction holding registers; only consulted in the matching wait state.
    always_ff @(posedge s_axi_aclk) begin
        if (aw_hs) aw_addr_q <= s_axi.awaddr;
        if (w_hs) begin
            w_data_q <= s_axi.wdata;
            w_strb_q <= s_axi.wstrb[NBYTES-1:0];
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit && cm_hit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (cm_idx == IDX_W'(i) && cm_strb[b])
                        regs[i][8*b +: 8] <= cm_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        r_state_nx = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_nx = R_DATA;
            R_DATA:  if (s_axi.rready) r_state_nx = R_IDLE;
            default: r_state_nx = R_IDLE;
        endcase
    end

    assign rd_hit = addr_hit(s_axi.araddr);
    assign rd_idx = addr_idx(s_axi.araddr);

    // Sampling the array on the AR edge returns the pre-write value on a same-cycle write.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= '0;
        end else begin
            r_state <= r_state_nx;
            if (ar_hs) begin
                rdata_q <= rd_hit ? regs[rd_idx] : '0;
                rresp_q <= rd_hit ? RESP_OKAY : MISS_RESP;
            end
        end
    end

endmodule
